// File: rtl/fp_mult_round_pack.sv
// Two-stage single-precision multiplier back end: classify, normalize, round to nearest even, saturate and pack.
// Valid/ready semantics: a transfer occurs on a rising edge where valid & ready; valid is held with stable data until the transfer.
module fp_mult_round_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [47:0] in_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  typedef enum logic [1:0] {SpecNone, SpecNan, SpecInf, SpecZero} specCode_t;

  logic        s1Valid, s1Sign, s1Guard, s1Sticky;
  logic [22:0] s1Mant;
  logic [9:0]  s1Exp;
  specCode_t   s1Special;

  logic        s2Valid;
  logic [31:0] s2Result;
  logic [3:0]  s2Flags;

  logic s1Load, s2Load;

  assign s2Load    = !s2Valid || out_ready;
  assign s1Load    = !s1Valid || s2Load;
  assign in_ready  = s1Load;
  assign out_valid = s2Valid;
  assign out_result = s2Result;
  assign out_flags  = s2Flags;

  // Stage 1: classification, sign, exponent sum and normalization.
  logic [7:0]  aExp, bExp;
  logic        aZero, bZero, aInf, bInf, aNan, bNan;
  specCode_t   specNext;
  logic [9:0]  expNext;
  logic [22:0] mantNext;
  logic        guardNext, stickyNext;

  assign aExp  = in_a[30:23];
  assign bExp  = in_b[30:23];
  assign aZero = (aExp == 8'd0);
  assign bZero = (bExp == 8'd0);
  assign aInf  = (aExp == 8'hFF) && (in_a[22:0] == 23'd0);
  assign bInf  = (bExp == 8'hFF) && (in_b[22:0] == 23'd0);
  assign aNan  = (aExp == 8'hFF) && (in_a[22:0] != 23'd0);
  assign bNan  = (bExp == 8'hFF) && (in_b[22:0] != 23'd0);

  always_comb begin
    specNext   = SpecNone;
    expNext    = {2'b00, aExp} + {2'b00, bExp} - 10'd127 + {9'd0, in_prod[47]};
    mantNext   = in_prod[45:23];
    guardNext  = in_prod[22];
    stickyNext = |in_prod[21:0];
    if (in_prod[47]) begin
      mantNext   = in_prod[46:24];
      guardNext  = in_prod[23];
      stickyNext = |in_prod[22:0];
    end
    if (aNan || bNan || (aInf && bZero) || (bInf && aZero)) specNext = SpecNan;
    else if (aInf || bInf)                                 specNext = SpecInf;
    else if (aZero || bZero)                               specNext = SpecZero;
  end

  // Stage 2: round, then saturate against the post-round exponent.
  logic        roundUp;
  logic [23:0] mantRnd;
  logic [9:0]  expFinal;
  logic [31:0] resultNext;
  logic [3:0]  flagsNext;

  assign roundUp  = s1Guard && (s1Sticky || s1Mant[0]);
  assign mantRnd  = {1'b0, s1Mant} + {23'd0, roundUp};
  assign expFinal = s1Exp + {9'd0, mantRnd[23]};

  always_comb begin
    resultNext = {s1Sign, expFinal[7:0], mantRnd[22:0]};
    flagsNext  = {3'b000, s1Guard || s1Sticky};
    case (s1Special)
      SpecNan: begin
        resultNext = 32'h7FC00000;
        flagsNext  = 4'b1000;
      end
      SpecInf: begin
        resultNext = {s1Sign, 8'hFF, 23'd0};
        flagsNext  = 4'b0000;
      end
      SpecZero: begin
        resultNext = {s1Sign, 31'd0};
        flagsNext  = 4'b0000;
      end
      default: begin
        if ($signed(expFinal) >= 10'sd255) begin
          resultNext = {s1Sign, 8'hFF, 23'd0};
          flagsNext  = 4'b0101;
        end else if ($signed(expFinal) <= 10'sd0) begin
          resultNext = {s1Sign, 31'd0};
          flagsNext  = 4'b0011;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) s1Valid <= 1'b0;
    else if (s1Load) s1Valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1Load && in_valid) begin
      s1Sign    <= in_a[31] ^ in_b[31];
      s1Special <= specNext;
      s1Exp     <= expNext;
      s1Mant    <= mantNext;
      s1Guard   <= guardNext;
      s1Sticky  <= stickyNext;
    end
  end

  // Output registers are cleared on reset so the idle port reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid  <= 1'b0;
      s2Result <= 32'd0;
      s2Flags  <= 4'd0;
    end else if (s2Load) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Result <= resultNext;
        s2Flags  <= flagsNext;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_round_pack.sv
// Directed bench for fp_mult_round_pack: arithmetic, specials, saturation, backpressure and reset.
module tb_fp_mult_round_pack;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [47:0] in_prod;
  logic [3:0]  out_flags;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [47:0] p;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  fp_mult_round_pack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one op into an empty pipeline; latOk means out_valid was low one edge after issue and high after two.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [47:0] p,
                            output logic [31:0] res, output logic [3:0] flg, output bit latOk);
    logic v1, v2;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_prod = p; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    v1 = out_valid;
    @(posedge clk);
    @(negedge clk);
    v2  = out_valid;
    res = out_result;
    flg = out_flags;
    latOk = (v1 === 1'b0) && (v2 === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_prod = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || out_flags !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b result=%h flags=%b expected valid=0 result=00000000 flags=0000",
               out_valid, out_result, out_flags);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected in_ready=1 out_valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_normal();
    vec_t v [7] = '{
      '{32'h3FC00000, 32'h40000000, 48'h600000000000, 32'h40400000, 4'b0000},
      '{32'h3F800001, 32'h3FC00000, 48'h600000C00000, 32'h3FC00002, 4'b0001},
      '{32'hBFC00000, 32'h40000000, 48'h600000000000, 32'hC0400000, 4'b0000},
      '{32'h3F800000, 32'h3F800000, 48'h7FFFFFC00000, 32'h40000000, 4'b0001},
      '{32'h3F800000, 32'h3F800000, 48'h400000400000, 32'h3F800000, 4'b0001},
      '{32'h3F800000, 32'h3F800000, 48'h400000600000, 32'h3F800001, 4'b0001},
      '{32'h3FC00000, 32'h3FC00000, 48'h900000000000, 32'h40100000, 4'b0000}
    };
    logic [31:0] res;
    logic [3:0]  flg;
    bit          latOk;
    for (int i = 0; i < 7; i++) begin
      run_single(v[i].a, v[i].b, v[i].p, res, flg, latOk);
      checks++;
      if (!latOk) begin
        errors++;
        $display("FAIL normal[%0d] latency: result not valid exactly two edges after issue", i);
      end
      checks++;
      if (res !== v[i].r) begin
        errors++;
        $display("FAIL normal[%0d] result: got %h expected %h", i, res, v[i].r);
      end
      checks++;
      if (flg !== v[i].f) begin
        errors++;
        $display("FAIL normal[%0d] flags: got %b expected %b", i, flg, v[i].f);
      end
    end
  endtask

  task automatic test_boundary();
    vec_t v [6] = '{
      '{32'h7F000000, 32'h7F000000, 48'h400000000000, 32'h7F800000, 4'b0101},
      '{32'h00800000, 32'h00800000, 48'h400000000000, 32'h00000000, 4'b0011},
      '{32'h7F000000, 32'h3F800000, 48'h400000000000, 32'h7F000000, 4'b0000},
      '{32'h7F000000, 32'h40000000, 48'h400000000000, 32'h7F800000, 4'b0101},
      '{32'h20000000, 32'h1F800000, 48'h400000000000, 32'h00000000, 4'b0011},
      '{32'h20000000, 32'h20000000, 48'h400000000000, 32'h00800000, 4'b0000}
    };
    logic [31:0] res;
    logic [3:0]  flg;
    bit          latOk;
    for (int i = 0; i < 6; i++) begin
      run_single(v[i].a, v[i].b, v[i].p, res, flg, latOk);
      checks++;
      if (!latOk || res !== v[i].r || flg !== v[i].f) begin
        errors++;
        $display("FAIL boundary[%0d]: got result=%h flags=%b latOk=%0d expected result=%h flags=%b latOk=1",
                 i, res, flg, latOk, v[i].r, v[i].f);
      end
    end
  endtask

  task automatic test_special();
    vec_t v [7] = '{
      '{32'h7FC00000, 32'h3F800000, 48'hFFFFFFFFFFFF, 32'h7FC00000, 4'b1000},
      '{32'hFF800000, 32'h00000000, 48'hFFFFFFFFFFFF, 32'h7FC00000, 4'b1000},
      '{32'hFF800000, 32'h40000000, 48'hFFFFFFFFFFFF, 32'hFF800000, 4'b0000},
      '{32'h80000000, 32'h40000000, 48'hFFFFFFFFFFFF, 32'h80000000, 4'b0000},
      '{32'h00000001, 32'h3F800000, 48'hFFFFFFFFFFFF, 32'h00000000, 4'b0000},
      '{32'h7F800000, 32'h7F800001, 48'hFFFFFFFFFFFF, 32'h7FC00000, 4'b1000},
      '{32'h7F800000, 32'h7F800000, 48'hFFFFFFFFFFFF, 32'h7F800000, 4'b0000}
    };
    logic [31:0] res;
    logic [3:0]  flg;
    bit          latOk;
    for (int i = 0; i < 7; i++) begin
      run_single(v[i].a, v[i].b, v[i].p, res, flg, latOk);
      checks++;
      if (!latOk || res !== v[i].r || flg !== v[i].f) begin
        errors++;
        $display("FAIL special[%0d]: got result=%h flags=%b latOk=%0d expected result=%h flags=%b latOk=1",
                 i, res, flg, latOk, v[i].r, v[i].f);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] heldRes, expRes;
    int          accepted = 0;
    bit          sawStall = 1'b0;
    bit          holding  = 1'b0;
    for (int k = 0; k < 5; k++) exp_q.push_back(32'h40000000 + (32'(k) << 23));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (accepted < 5);
      in_a      = {1'b0, 8'(127 + accepted), 23'd0};
      in_b      = 32'h40000000;
      in_prod   = 48'h400000000000;
      #1;
      if (holding) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== heldRes) begin
          errors++;
          $display("FAIL stall_hold c=%0d: got valid=%b result=%h expected valid=1 result=%h",
                   c, out_valid, out_result, heldRes);
        end
      end
      if (in_ready === 1'b0) sawStall = 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra c=%0d: got result=%h expected no further output", c, out_result);
        end else begin
          expRes = exp_q.pop_front();
          if (out_result !== expRes || out_flags !== 4'b0000) begin
            errors++;
            $display("FAIL stream_order c=%0d: got %h/%b expected %h/0000", c, out_result, out_flags, expRes);
          end
        end
      end
      holding = (out_valid === 1'b1) && !out_ready;
      heldRes = out_result;
      if (in_valid && in_ready === 1'b1) accepted++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (!sawStall) begin
      errors++;
      $display("FAIL stall_in_ready: got in_ready never low expected low while both stages full");
    end
    checks++;
    if (exp_q.size() != 0 || accepted != 5) begin
      errors++;
      $display("FAIL stream_count: got %0d missing outputs, %0d accepted expected 0 missing, 5 accepted",
               exp_q.size(), accepted);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [3:0]  flg;
    bit          latOk;
    bit          stale = 1'b0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 32'h3FC00000; in_b = 32'h40000000; in_prod = 48'h600000000000;
    @(posedge clk);
    @(negedge clk);
    in_a = 32'hBFC00000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid: got out_valid=%b expected 0", out_valid);
    end
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_stale: got stale=%0d in_ready=%b expected stale=0 in_ready=1", stale, in_ready);
    end
    run_single(32'h3F800001, 32'h3FC00000, 48'h600000C00000, res, flg, latOk);
    checks++;
    if (!latOk || res !== 32'h3FC00002 || flg !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_new_op: got result=%h flags=%b latOk=%0d expected result=3fc00002 flags=0001 latOk=1",
               res, flg, latOk);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_boundary();
    test_special();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
